// File: rtl/miss_alloc_ctrl_if.sv
// Bus bundle for miss_alloc_ctrl: miss/invalidate requests, LRU command port,
// writeback and fill handshakes, completion reporting. Controller side is "slave".
interface miss_alloc_ctrl_if #(
  parameter int NUM_WAYS = 4,
  parameter int ADDR_W   = 32
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic              miss_valid_i;
  logic              miss_ready_o;
  logic [ADDR_W-1:0] miss_addr_i;
  logic              inv_valid_i;
  logic              inv_ready_o;
  logic [WAY_W-1:0]  inv_way_i;
  logic              ls_valid_o;
  logic [1:0]        ls_op_o;
  logic [WAY_W-1:0]  ls_way_o;
  logic              lru_valid_i;
  logic [NUM_WAYS-1:0] lru_way_i;
  logic [NUM_WAYS-1:0] dirty_i;
  logic              wb_valid_o;
  logic [WAY_W-1:0]  wb_way_o;
  logic              wb_ready_i;
  logic              fill_valid_o;
  logic [ADDR_W-1:0] fill_addr_o;
  logic [WAY_W-1:0]  fill_way_o;
  logic              fill_done_i;
  logic              alloc_done_o;
  logic [WAY_W-1:0]  alloc_way_o;
  logic              alloc_err_o;

  modport slave (
    input  miss_valid_i, miss_addr_i, inv_valid_i, inv_way_i, lru_valid_i,
           lru_way_i, dirty_i, wb_ready_i, fill_done_i,
    output miss_ready_o, inv_ready_o, ls_valid_o, ls_op_o, ls_way_o,
           wb_valid_o, wb_way_o, fill_valid_o, fill_addr_o, fill_way_o,
           alloc_done_o, alloc_way_o, alloc_err_o
  );

  modport master (
    output miss_valid_i, miss_addr_i, inv_valid_i, inv_way_i, lru_valid_i,
           lru_way_i, dirty_i, wb_ready_i, fill_done_i,
    input  miss_ready_o, inv_ready_o, ls_valid_o, ls_op_o, ls_way_o,
           wb_valid_o, wb_way_o, fill_valid_o, fill_addr_o, fill_way_o,
           alloc_done_o, alloc_way_o, alloc_err_o
  );
endinterface

// File: rtl/miss_alloc_ctrl.sv
// Cache miss allocation controller: victim lookup, optional writeback, line fill.
// Define MISS_ALLOC_TIMEOUT_EN to add an 8-bit WB/FILL watchdog that aborts with alloc_err_o.
module miss_alloc_ctrl #(
  parameter int NUM_WAYS = 4,
  parameter int ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  miss_alloc_ctrl_if.slave    bus,
  output logic [2:0]          state_dbg_o
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  // Handshakes: a transfer happens on the rising edge where valid and ready are both 1.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic                err_q, err_d;
  logic [WAY_W-1:0]    lru_enc;
  logic                lru_onehot;
`ifdef MISS_ALLOC_TIMEOUT_EN
  logic [7:0]          wdog_q, wdog_d;
`endif

  always_comb begin
    lru_enc = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (bus.lru_way_i[i]) lru_enc = lru_enc | WAY_W'(i);
    end
    lru_onehot = (bus.lru_way_i != '0) &&
                 ((bus.lru_way_i & (bus.lru_way_i - NUM_WAYS'(1))) == '0);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    victim_d = victim_q;
    err_d    = 1'b0;
`ifdef MISS_ALLOC_TIMEOUT_EN
    wdog_d   = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        // An invalidate wins; the miss simply waits for a cycle without one.
        if (!bus.inv_valid_i && bus.miss_valid_i) begin
          addr_d  = bus.miss_addr_i;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        victim_d = lru_enc;
`ifdef MISS_ALLOC_TIMEOUT_EN
        wdog_d   = '0;
`endif
        if (!bus.lru_valid_i || !lru_onehot) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.dirty_i[lru_enc]) begin
          state_d = S_WB;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WB: begin
        if (bus.wb_ready_i) begin
          state_d = S_FILL;
`ifdef MISS_ALLOC_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
`ifdef MISS_ALLOC_TIMEOUT_EN
        else begin
          wdog_d = wdog_q + 8'd1;
          if (wdog_d == 8'hFF) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
`endif
      end
      S_FILL: begin
        if (bus.fill_done_i) begin
          state_d = S_DONE;
        end
`ifdef MISS_ALLOC_TIMEOUT_EN
        else begin
          wdog_d = wdog_q + 8'd1;
          if (wdog_d == 8'hFF) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      victim_q <= '0;
      err_q    <= 1'b0;
`ifdef MISS_ALLOC_TIMEOUT_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      victim_q <= victim_d;
      err_q    <= err_d;
`ifdef MISS_ALLOC_TIMEOUT_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  always_comb begin
    bus.inv_ready_o  = (state_q == S_IDLE);
    bus.miss_ready_o = (state_q == S_IDLE) && !bus.inv_valid_i;
    bus.ls_valid_o   = 1'b0;
    bus.ls_op_o      = 2'b00;
    bus.ls_way_o     = '0;
    // reset_n gating keeps the LRU port silent while reset is held.
    if (state_q == S_IDLE && bus.inv_valid_i && reset_n) begin
      bus.ls_valid_o = 1'b1;
      bus.ls_op_o    = 2'b11;
      bus.ls_way_o   = bus.inv_way_i;
    end else if (state_q == S_LOOKUP) begin
      bus.ls_valid_o = 1'b1;
      bus.ls_op_o    = 2'b10;
    end
    bus.wb_valid_o   = (state_q == S_WB);
    bus.wb_way_o     = (state_q == S_WB) ? victim_q : '0;
    bus.fill_valid_o = (state_q == S_FILL);
    bus.fill_addr_o  = (state_q == S_FILL) ? addr_q : '0;
    bus.fill_way_o   = (state_q == S_FILL) ? victim_q : '0;
    bus.alloc_done_o = (state_q == S_DONE);
    bus.alloc_way_o  = (state_q == S_DONE) ? victim_q : '0;
    bus.alloc_err_o  = err_q;
  end

  assign state_dbg_o = state_q;
endmodule

// File: tb/tb_miss_alloc_ctrl.sv
// Self-checking bench for miss_alloc_ctrl: directed cases, randomized misses,
// and a result scoreboard fed when each miss is driven.
module tb_miss_alloc_ctrl;
  localparam int NUM_WAYS = 4;
  localparam int ADDR_W   = 32;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOOKUP = 3'd1, ST_WB = 3'd2,
                         ST_FILL = 3'd3, ST_DONE = 3'd4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] state_dbg;
  int         n_tests = 0;
  int         n_fail  = 0;
  // Entry: {err, done, way[1:0]}
  logic [3:0] exp_q[$];

  miss_alloc_ctrl_if #(.NUM_WAYS(NUM_WAYS), .ADDR_W(ADDR_W)) bus();

  miss_alloc_ctrl #(.NUM_WAYS(NUM_WAYS), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every completion or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && (bus.alloc_done_o || bus.alloc_err_o)) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected", {bus.alloc_err_o, bus.alloc_done_o, bus.alloc_way_o}, 4'b0000);
      end else begin
        check_eq("sb_result", {bus.alloc_err_o, bus.alloc_done_o, bus.alloc_way_o}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic run_miss(input logic [31:0] addr, input logic lv, input logic [3:0] lru,
                          input logic [3:0] dirty, input int wb_wait, input int fill_wait);
    logic       err;
    logic [1:0] vic;
    logic       is_dirty;
    err = !lv || ($countones(lru) != 1);
    vic = 2'd0;
    for (int i = 0; i < NUM_WAYS; i++) if (lru[i]) vic = 2'(i);
    is_dirty = dirty[vic];
    exp_q.push_back(err ? 4'b1000 : {2'b01, vic});

    tick();
    bus.inv_valid_i  = 1'b0;
    bus.miss_valid_i = 1'b1;
    bus.miss_addr_i  = addr;
    bus.lru_valid_i  = lv;
    bus.lru_way_i    = lru;
    bus.dirty_i      = dirty;
    bus.wb_ready_i   = 1'b0;
    bus.fill_done_i  = 1'b0;
    sample();
    check_eq("hs_miss_ready", bus.miss_ready_o, 1'b1);
    check_eq("idle_ls_valid", {bus.ls_valid_o, bus.ls_op_o, bus.ls_way_o}, 5'd0);

    tick();
    bus.miss_valid_i = 1'b0;
    bus.miss_addr_i  = ~addr;
    bus.wb_ready_i   = 1'b1;
    bus.fill_done_i  = 1'b1;
    sample();
    check_eq("lookup_state", state_dbg, ST_LOOKUP);
    check_eq("lookup_ls", {bus.ls_valid_o, bus.ls_op_o, bus.ls_way_o}, {1'b1, 2'b10, 2'b00});
    check_eq("lookup_ready", {bus.miss_ready_o, bus.inv_ready_o}, 2'b00);

    if (err) begin
      tick();
      bus.lru_valid_i = 1'b0;
      bus.wb_ready_i  = 1'b0;
      bus.fill_done_i = 1'b0;
      sample();
      check_eq("err_state", state_dbg, ST_IDLE);
      check_eq("err_pulse", bus.alloc_err_o, 1'b1);
      check_eq("err_no_fill", bus.fill_valid_o, 1'b0);
      tick();
      sample();
      check_eq("err_pulse_end", bus.alloc_err_o, 1'b0);
      return;
    end

    if (is_dirty) begin
      for (int j = 0; j <= wb_wait; j++) begin
        tick();
        bus.lru_valid_i = 1'b0;
        bus.wb_ready_i  = (j == wb_wait);
        bus.fill_done_i = 1'b1;
        sample();
        check_eq("wb_valid", {bus.wb_valid_o, bus.wb_way_o}, {1'b1, vic});
        check_eq("wb_no_fill", bus.fill_valid_o, 1'b0);
      end
    end

    for (int j = 0; j <= fill_wait; j++) begin
      tick();
      bus.lru_valid_i = 1'b0;
      bus.wb_ready_i  = 1'b1;
      bus.fill_done_i = (j == fill_wait);
      sample();
      check_eq("fill_valid", {bus.fill_valid_o, bus.fill_way_o}, {1'b1, vic});
      check_eq("fill_addr", bus.fill_addr_o, addr);
      check_eq("fill_no_wb", bus.wb_valid_o, 1'b0);
    end

    tick();
    bus.fill_done_i = 1'b0;
    bus.wb_ready_i  = 1'b0;
    sample();
    check_eq("done_state", state_dbg, ST_DONE);
    check_eq("done_out", {bus.alloc_done_o, bus.alloc_way_o}, {1'b1, vic});

    tick();
    sample();
    check_eq("back_idle", state_dbg, ST_IDLE);
    check_eq("done_pulse_end", bus.alloc_done_o, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         n;
    logic [3:0] lru;
    logic       lv;

    reset_n          = 1'b0;
    bus.miss_valid_i = 1'b1;
    bus.miss_addr_i  = 32'hDEAD_BEEF;
    bus.inv_valid_i  = 1'b0;
    bus.inv_way_i    = 2'd0;
    bus.lru_valid_i  = 1'b1;
    bus.lru_way_i    = 4'b0010;
    bus.dirty_i      = 4'hF;
    bus.wb_ready_i   = 1'b1;
    bus.fill_done_i  = 1'b1;

    // Reset with a pending miss.
    repeat (3) sample();
    check_eq("rst_state", state_dbg, ST_IDLE);
    check_eq("rst_ready", {bus.miss_ready_o, bus.inv_ready_o}, 2'b11);
    check_eq("rst_ls", {bus.ls_valid_o, bus.ls_op_o, bus.ls_way_o}, 5'd0);
    check_eq("rst_wb", {bus.wb_valid_o, bus.wb_way_o}, 3'd0);
    check_eq("rst_fill", {bus.fill_valid_o, bus.fill_way_o, bus.fill_addr_o}, 35'd0);
    check_eq("rst_alloc", {bus.alloc_done_o, bus.alloc_way_o, bus.alloc_err_o}, 4'd0);
    reset_n = 1'b1;
    #1;
    check_eq("rel_miss_ready", bus.miss_ready_o, 1'b1);
    bus.miss_valid_i = 1'b0;
    bus.lru_valid_i  = 1'b0;
    bus.dirty_i      = 4'h0;
    bus.wb_ready_i   = 1'b0;
    bus.fill_done_i  = 1'b0;

    // Clean victim, minimum latency; then dirty victim with writeback stall.
    run_miss(32'h0000_1000, 1'b1, 4'b0100, 4'b0000, 0, 0);
    run_miss(32'h0000_1000, 1'b1, 4'b0100, 4'b0100, 5, 0);

    // Invalidate and miss together: invalidate first, miss the next cycle.
    tick();
    bus.inv_valid_i  = 1'b1;
    bus.inv_way_i    = 2'd3;
    bus.miss_valid_i = 1'b1;
    bus.miss_addr_i  = 32'h0000_2000;
    sample();
    check_eq("inv_ls", {bus.ls_valid_o, bus.ls_op_o, bus.ls_way_o}, {1'b1, 2'b11, 2'd3});
    check_eq("inv_ready", {bus.miss_ready_o, bus.inv_ready_o}, 2'b01);
    check_eq("inv_state", state_dbg, ST_IDLE);
    run_miss(32'h0000_2000, 1'b1, 4'b0001, 4'b1110, 0, 2);

    // LRU errors: two-hot, zero, not valid.
    run_miss(32'h0000_1000, 1'b1, 4'b0110, 4'b0000, 0, 0);
    run_miss(32'h0000_1234, 1'b1, 4'b0000, 4'b0000, 0, 0);
    run_miss(32'h0000_5678, 1'b0, 4'b1000, 4'b0000, 0, 0);

    // Reset during FILL abandons the allocation silently.
    tick();
    bus.miss_valid_i = 1'b1;
    bus.miss_addr_i  = 32'h0000_3000;
    bus.lru_valid_i  = 1'b1;
    bus.lru_way_i    = 4'b1000;
    bus.dirty_i      = 4'b0000;
    bus.fill_done_i  = 1'b0;
    tick();
    bus.miss_valid_i = 1'b0;
    tick();
    bus.lru_valid_i  = 1'b0;
    tick();
    sample();
    check_eq("pre_rst_fill", {state_dbg, bus.fill_valid_o}, {ST_FILL, 1'b1});
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_state", state_dbg, ST_IDLE);
    check_eq("mid_rst_out", {bus.fill_valid_o, bus.alloc_done_o, bus.alloc_err_o}, 3'b000);
    repeat (3) begin
      sample();
      check_eq("mid_rst_quiet", {bus.alloc_done_o, bus.alloc_err_o}, 2'b00);
    end
    tick();
    reset_n = 1'b1;
    sample();
    check_eq("post_rst", {state_dbg, bus.miss_ready_o}, {ST_IDLE, 1'b1});
    repeat (2) begin
      sample();
      check_eq("post_rst_quiet", {bus.alloc_done_o, bus.alloc_err_o}, 2'b00);
    end

    // Long fill: watchdog abort when enabled, indefinite wait otherwise.
    tick();
    bus.miss_valid_i = 1'b1;
    bus.miss_addr_i  = 32'h0000_4000;
    bus.lru_valid_i  = 1'b1;
    bus.lru_way_i    = 4'b0010;
    bus.dirty_i      = 4'b0000;
    bus.fill_done_i  = 1'b0;
`ifdef MISS_ALLOC_TIMEOUT_EN
    exp_q.push_back(4'b1000);
`else
    exp_q.push_back(4'b0101);
`endif
    tick();
    bus.miss_valid_i = 1'b0;
    tick();
    bus.lru_valid_i  = 1'b0;
    n = 0;
`ifdef MISS_ALLOC_TIMEOUT_EN
    sample();
    while (bus.fill_valid_o && n < 400) begin
      n++;
      tick();
      sample();
    end
    check_eq("wdog_fill_cycles", n, 255);
    check_eq("wdog_err", {bus.alloc_err_o, bus.alloc_done_o}, 2'b10);
    check_eq("wdog_idle", state_dbg, ST_IDLE);
`else
    for (int k = 0; k < 300; k++) begin
      sample();
      if (bus.fill_valid_o) n++;
      tick();
    end
    bus.fill_done_i = 1'b1;
    sample();
    check_eq("long_fill_cycles", n, 300);
    check_eq("long_fill_hold", bus.fill_valid_o, 1'b1);
    tick();
    bus.fill_done_i = 1'b0;
    sample();
    check_eq("long_fill_done", {bus.alloc_done_o, bus.alloc_way_o}, 3'b101);
`endif
    tick();

    // Randomized misses.
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 4) == 0) lru = 4'($urandom_range(0, 15));
      else                           lru = 4'b0001 << $urandom_range(0, 3);
      lv = ($urandom_range(0, 7) != 0);
      run_miss($urandom, lv, lru, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3));
    end

    tick();
    sample();
    check_eq("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/miss_alloc_ctrl.md
MISS_ALLOC_CTRL -- requirements
Module: miss_alloc_ctrl

Interface
REQ-001 Parameter NUM_WAYS, default 4: number of cache ways; one-hot way vectors are NUM_WAYS wide, encoded way fields are $clog2(NUM_WAYS) wide.
REQ-002 Parameter ADDR_W, default 32: miss/fill address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 miss_valid_i  input  1  miss request pending; miss_ready_o  output  1  controller accepts the miss; miss_addr_i  input  ADDR_W  line address of the miss.
REQ-006 inv_valid_i  input  1  invalidate request; inv_ready_o  output  1  invalidate accepted; inv_way_i  input  $clog2(NUM_WAYS)  way to invalidate.
REQ-007 ls_valid_o  output  1, ls_op_o  output  2, ls_way_o  output  $clog2(NUM_WAYS): command port to the LRU stage (op 2'b10 = allocate, 2'b11 = invalidate).
REQ-008 lru_valid_i  input  1, lru_way_i  input  NUM_WAYS: one-hot victim from the LRU stage, valid in the same cycle as an allocate command.
REQ-009 dirty_i  input  NUM_WAYS  per-way dirty bits.
REQ-010 wb_valid_o  output  1, wb_way_o  output  $clog2(NUM_WAYS), wb_ready_i  input  1: writeback handshake.
REQ-011 fill_valid_o  output  1, fill_addr_o  output  ADDR_W, fill_way_o  output  $clog2(NUM_WAYS), fill_done_i  input  1: line-fill request and completion.
REQ-012 alloc_done_o  output  1, alloc_way_o  output  $clog2(NUM_WAYS), alloc_err_o  output  1: completion pulse, allocated way, and error pulse.

Function
REQ-013 The FSM SHALL have states IDLE, LOOKUP, WB, FILL and DONE.
REQ-014 IDLE: inv_ready_o=1 always; miss_ready_o=1 only when inv_valid_i=0, so an invalidate has priority over a simultaneous miss and the miss is taken on a later cycle.
REQ-015 Invalidate handshake in IDLE: ls_valid_o=1, ls_op_o=2'b11 and ls_way_o=inv_way_i for exactly that cycle, combinationally; the FSM stays in IDLE.
REQ-016 Miss handshake: capture miss_addr_i and go to LOOKUP.
REQ-017 LOOKUP (one cycle): ls_valid_o=1, ls_op_o=2'b10, ls_way_o=0.
- Capture lru_way_i, encoded to binary, as the victim.
- If lru_valid_i=0 or lru_way_i is not exactly one-hot: pulse alloc_err_o and return to IDLE.
- Otherwise go to WB if dirty_i[victim]=1, else to FILL.
REQ-018 WB: hold wb_valid_o=1 and wb_way_o=victim until wb_ready_i=1, then go to FILL.
REQ-019 FILL: hold fill_valid_o=1 with the captured address and victim until fill_done_i=1, then go to DONE.
REQ-020 DONE (one cycle): alloc_done_o=1 and alloc_way_o=victim, then go to IDLE.
REQ-021 Outside IDLE, miss_ready_o=0 and inv_ready_o=0; outside IDLE and LOOKUP, ls_valid_o=0.
REQ-022 Whenever ls_valid_o=0, ls_op_o and ls_way_o SHALL be 0.
REQ-023 Minimum latency from miss handshake to alloc_done_o, clean victim with fill_done_i already high: 3 cycles (LOOKUP, FILL, DONE).
REQ-024 fill_done_i and wb_ready_i SHALL be ignored outside FILL and WB respectively.

Reset
REQ-025 While reset_n=0: FSM in IDLE; captured address, victim and watchdog counter cleared to 0; every output 0 except miss_ready_o and inv_ready_o, which follow REQ-014.
REQ-026 Reset asserted mid-allocation SHALL abandon the operation with no alloc_done_o or alloc_err_o pulse.

Configuration
REQ-027 Macro MISS_ALLOC_TIMEOUT_EN, when defined, SHALL add an 8-bit watchdog that clears on entry to WB or FILL and increments each cycle spent there.
- When the count reaches 255: pulse alloc_err_o, return to IDLE, no alloc_done_o.
- When the macro is undefined: no counter, and WB/FILL wait indefinitely.

Verification
REQ-028 Reset with miss_valid_i=1 -> all outputs 0 except ready; release reset -> miss_ready_o=1.
REQ-029 Miss addr 0x1000, lru_way_i=4'b0100, dirty_i=0, fill_done_i=1 -> ls_op_o=2'b10 in LOOKUP; alloc_done_o 3 cycles after handshake with alloc_way_o=2.
REQ-030 Same miss with dirty_i=4'b0100, wb_ready_i held low 5 cycles -> wb_valid_o high 6 cycles with wb_way_o=2, then fill at 0x1000.
REQ-031 inv_valid_i=1 with inv_way_i=3 and miss_valid_i=1 in the same cycle -> ls_op_o=2'b11 and ls_way_o=3 that cycle; miss accepted the next cycle.
REQ-032 lru_way_i=4'b0110 in LOOKUP -> alloc_err_o pulse, back to IDLE, no fill_valid_o.
REQ-033 With MISS_ALLOC_TIMEOUT_EN defined and fill_done_i held 0 -> alloc_err_o 255 cycles after FILL entry; reset_n low during FILL -> immediate IDLE with no pulse.
